// File: rtl/constants.sv
// Shared encodings for the multicycle RV32I core: opcodes, ALU codes,
// datapath mux selects and the controller state type.
package constants;

  localparam logic [6:0] TYPE_R      = 7'b0110011;
  localparam logic [6:0] TYPE_I_ALU  = 7'b0010011;
  localparam logic [6:0] TYPE_I_LOAD = 7'b0000011;
  localparam logic [6:0] TYPE_S      = 7'b0100011;
  localparam logic [6:0] TYPE_B      = 7'b1100011;
  localparam logic [6:0] TYPE_J      = 7'b1101111;
  localparam logic [6:0] TYPE_U      = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, LUI
  } state_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse alu_op plus the instruction funct fields to an ALU code.
module alu_decoder
  import constants::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] alu_op,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // ADDI has immediate bits in instr[30], so only R-type may subtract
          3'b000:  alu_control = (op == TYPE_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing each RV32I instruction through the shared datapath;
// every enable/select is decoded from the current state.
module multicycle_controller
  import constants::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [2:0] imm_src,
  output logic       instr_done,
  output logic       illegal
);

  state_t     state, state_nxt;
  logic [1:0] alu_op;
  logic       pc_w, mem_w, ir_w, reg_w, done, bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = FETCH;
    pc_w       = 1'b0;
    mem_w      = 1'b0;
    ir_w       = 1'b0;
    reg_w      = 1'b0;
    done       = 1'b0;
    bad        = 1'b0;
    adr_src    = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    case (state)
      FETCH: begin
        ir_w = 1'b1; pc_w = 1'b1;
        alu_src_a = SRCA_PC; alu_src_b = SRCB_FOUR; result_src = RES_ALURESULT;
        state_nxt = DECODE;
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC; alu_src_b = SRCB_IMM;
        case (op)
          TYPE_I_LOAD, TYPE_S: state_nxt = MEMADR;
          TYPE_R:              state_nxt = EXECUTER;
          TYPE_I_ALU:          state_nxt = EXECUTEI;
          TYPE_B:              state_nxt = BRANCH;
          TYPE_J:              state_nxt = JAL;
          TYPE_U:              state_nxt = LUI;
          default: begin state_nxt = FETCH; bad = 1'b1; end
        endcase
      end
      MEMADR: begin
        alu_src_a = SRCA_RS1; alu_src_b = SRCB_IMM;
        state_nxt = (op == TYPE_S) ? MEMWRITE : MEMREAD;
      end
      MEMREAD:  begin adr_src = 1'b1; state_nxt = MEMWB; end
      MEMWB:    begin result_src = RES_DATA; reg_w = 1'b1; done = 1'b1; end
      MEMWRITE: begin adr_src = 1'b1; mem_w = 1'b1; done = 1'b1; end
      EXECUTER: begin
        alu_src_a = SRCA_RS1; alu_src_b = SRCB_RS2; alu_op = ALUOP_FUNCT;
        state_nxt = ALUWB;
      end
      EXECUTEI: begin
        alu_src_a = SRCA_RS1; alu_src_b = SRCB_IMM; alu_op = ALUOP_FUNCT;
        state_nxt = ALUWB;
      end
      ALUWB: begin reg_w = 1'b1; done = 1'b1; end
      BRANCH: begin
        alu_src_a = SRCA_RS1; alu_src_b = SRCB_RS2; alu_op = ALUOP_SUB;
        done = 1'b1;
        case (funct3)
          3'b000:  pc_w = zero;
          3'b001:  pc_w = ~zero;
          default: pc_w = 1'b0;
        endcase
      end
      // ALUOut already holds the target from DECODE; the ALU now forms the link
      JAL: begin
        alu_src_a = SRCA_OLDPC; alu_src_b = SRCB_FOUR; pc_w = 1'b1;
        state_nxt = ALUWB;
      end
      LUI: begin
        alu_src_a = SRCA_ZERO; alu_src_b = SRCB_IMM;
        state_nxt = ALUWB;
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    case (op)
      TYPE_I_ALU, TYPE_I_LOAD: imm_src = IMM_I;
      TYPE_S:                  imm_src = IMM_S;
      TYPE_B:                  imm_src = IMM_B;
      TYPE_J:                  imm_src = IMM_J;
      TYPE_U:                  imm_src = IMM_U;
      default:                 imm_src = IMM_I;
    endcase
  end

  alu_decoder u_alu_dec (
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_op      (alu_op),
    .alu_control (alu_control)
  );

  // state is already FETCH during reset, so only the side-effecting strobes need masking
  assign pc_write   = pc_w  & ~reset;
  assign ir_write   = ir_w  & ~reset;
  assign reg_write  = reg_w & ~reset;
  assign mem_write  = mem_w & ~reset;
  assign instr_done = done  & ~reset;
  assign illegal    = bad   & ~reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed per-cycle checks of the controller's output vector for each instruction class.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control, imm_src;
  logic       instr_done, illegal;

  int checks = 0;
  int failures = 0;
  logic [18:0] rec [8];
  int len;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .imm_src(imm_src), .instr_done(instr_done), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // expected-vector builder; field order matches sample()
  function automatic logic [18:0] v(input logic pw, input logic as, input logic mw,
      input logic iw, input logic rw, input logic [1:0] rs, input logic [1:0] sa,
      input logic [1:0] sb, input logic [2:0] ac, input logic [2:0] is,
      input logic d, input logic il);
    return {pw, as, mw, iw, rw, rs, sa, sb, ac, is, d, il};
  endfunction

  function automatic logic [18:0] sample();
    return {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
            alu_src_a, alu_src_b, alu_control, imm_src, instr_done, illegal};
  endfunction

  function automatic logic [18:0] fetch_v(input logic [2:0] is);
    return v(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, is, 0, 0);
  endfunction

  function automatic logic [18:0] decode_v(input logic [2:0] is);
    return v(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, is, 0, 0);
  endfunction

  // Called in a FETCH cycle; records each cycle until instr_done/illegal (bounded).
  task automatic run(input logic [31:0] instr, input logic z);
    int n;
    op = instr[6:0]; funct3 = instr[14:12]; funct7b5 = instr[30]; zero = z;
    #1;
    n = 0;
    rec[0] = sample();
    while (!(rec[n][1] || rec[n][0]) && n < 7) begin
      @(posedge clk); #1;
      n++;
      rec[n] = sample();
    end
    len = n + 1;
    @(posedge clk); #2;
  endtask

  initial begin
    // reset state
    @(posedge clk); #1;
    chk("rst.vec", sample(), v(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0, 0));
    @(negedge clk); reset = 1'b0; #1;
    chk("rst.fetch", sample(), fetch_v(3'b000));

    // add / sub
    run(32'h002081B3, 0);
    chk("add.len", len, 4);
    chk("add.c0", rec[0], fetch_v(3'b000));
    chk("add.c1", rec[1], decode_v(3'b000));
    chk("add.c2", rec[2], v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 0, 0));
    chk("add.c3", rec[3], v(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0));
    run(32'h402081B3, 0);
    chk("sub.len", len, 4);
    chk("sub.c2", rec[2], v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 0, 0));

    // funct decode of other R-type ops, and ADDI with instr[30] set
    run(32'h0020A1B3, 0);
    chk("slt.c2", rec[2][7:5], 3'b101);
    run(32'h0020E1B3, 0);
    chk("or.c2", rec[2][7:5], 3'b011);
    run(32'h0020F1B3, 0);
    chk("and.c2", rec[2][7:5], 3'b010);
    run(32'h0020C1B3, 0);
    chk("xor.c2", rec[2][7:5], 3'b000);
    chk("xor.len", len, 4);
    run(32'h40008093, 0);
    chk("addi.len", len, 4);
    chk("addi.c2", rec[2], v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0, 0));
    chk("addi.c3", rec[3], v(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0));

    // lw / sw
    run(32'h00402283, 0);
    chk("lw.len", len, 5);
    chk("lw.c2", rec[2], v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0, 0));
    chk("lw.c3", rec[3], v(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0));
    chk("lw.c4", rec[4], v(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0));
    run(32'h00502423, 0);
    chk("sw.len", len, 4);
    chk("sw.c1", rec[1], decode_v(3'b001));
    chk("sw.c2", rec[2], v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0, 0));
    chk("sw.c3", rec[3], v(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 1, 0));

    // branches
    run(32'h00208463, 1);
    chk("beq1.len", len, 3);
    chk("beq1.c2", rec[2], v(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 1, 0));
    run(32'h00208463, 0);
    chk("beq0.c2", rec[2], v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 1, 0));
    run(32'h00209463, 0);
    chk("bne0.len", len, 3);
    chk("bne0.c2", rec[2], v(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 1, 0));
    run(32'h00209463, 1);
    chk("bne1.pcw", rec[2][18], 1'b0);
    run(32'h0020C463, 1);
    chk("blt.pcw", rec[2][18], 1'b0);
    run(32'h0020C463, 0);
    chk("blt0.pcw", rec[2][18], 1'b0);

    // jal / lui
    run(32'h010000EF, 0);
    chk("jal.len", len, 4);
    chk("jal.c1", rec[1], decode_v(3'b011));
    chk("jal.c2", rec[2], v(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b011, 0, 0));
    chk("jal.c3", rec[3], v(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b011, 1, 0));
    run(32'h123452B7, 0);
    chk("lui.len", len, 4);
    chk("lui.c2", rec[2], v(0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 3'b000, 3'b100, 0, 0));

    // illegal opcode
    run(32'h0000007F, 0);
    chk("ill.len", len, 2);
    chk("ill.c1", rec[1], v(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 0, 1));
    #1;
    chk("ill.next", sample(), fetch_v(3'b000));
    run(32'h002081B3, 0);
    chk("post_ill.len", len, 4);

    // reset asserted mid-MEMREAD, held for two edges
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mr.adr", adr_src, 1'b1);
    reset = 1'b1; #1;
    chk("mr.rst0", sample(), v(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0, 0));
    @(posedge clk); #1;
    chk("mr.rst1", sample(), v(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0, 0));
    @(posedge clk); #1;
    chk("mr.rst2", sample(), v(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0, 0));
    @(negedge clk); reset = 1'b0; #1;
    chk("mr.fetch", sample(), fetch_v(3'b000));
    run(32'h00402283, 0);
    chk("mr.lw.len", len, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Main control unit for the multicycle RV32I core. It sits directly downstream of the shared `constants` package and of the instruction register, and upstream of the datapath muxes, ALU, register file and unified memory. It sequences each instruction through a Moore FSM and drives every datapath enable and select. It decodes opcode/funct fields into ALU control codes and immediate type.

Parameters:
- None. All encodings come from the shared package.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- op  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag, valid in BRANCH state
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write enable
- ir_write  out  1  instruction and OldPC register enable
- reg_write  out  1  register-file write enable
- result_src  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_src_a  out  2  ALU operand A: 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero
- alu_src_b  out  2  ALU operand B: 00 = rs2, 01 = ImmExt, 10 = constant 4
- alu_control  out  3  ALU operation code
- imm_src  out  3  immediate type: I = 000, S = 001, B = 010, J = 011, U = 100
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- illegal  out  1  one-cycle pulse for an unsupported opcode

Behaviour:
- All outputs are Moore, decoded from the state register. imm_src and the funct-based ALU decode are combinational from op/funct3/funct7b5.
- Reset: state is forced to FETCH asynchronously.
  - While reset is high, pc_write, ir_write, reg_write, mem_write, instr_done and illegal are forced to 0.
  - All other outputs take their FETCH values.
- ALU codes: ADD = 000, SUB = 001, AND = 010, OR = 011, SLT = 101.
- States, their outputs, and next state (any output not listed is 0 or don't-care):
  - FETCH: adr_src = 0, ir_write = 1, A = PC, B = 4, ADD, result_src = 10, pc_write = 1. Next: DECODE.
  - DECODE: A = OldPC, B = Imm, ADD (precomputes branch/jump target). Next by op:
    - TYPE_I_LOAD or TYPE_S → MEMADR
    - TYPE_R → EXECUTER
    - TYPE_I_ALU → EXECUTEI
    - TYPE_B → BRANCH
    - TYPE_J → JAL
    - TYPE_U → LUI
    - any other op → FETCH with illegal = 1 for that DECODE cycle
  - MEMADR: A = rs1, B = Imm, ADD. Next: MEMREAD for a load, MEMWRITE for a store.
  - MEMREAD: adr_src = 1, result_src = 00. Next: MEMWB.
  - MEMWB: result_src = 01, reg_write = 1, instr_done = 1. Next: FETCH.
  - MEMWRITE: adr_src = 1, result_src = 00, mem_write = 1, instr_done = 1. Next: FETCH.
  - EXECUTER: A = rs1, B = rs2, funct decode. Next: ALUWB.
  - EXECUTEI: A = rs1, B = Imm, funct decode. Next: ALUWB.
  - ALUWB: result_src = 00, reg_write = 1, instr_done = 1. Next: FETCH.
  - BRANCH: A = rs1, B = rs2, SUB, result_src = 00.
    - pc_write = zero when funct3 = 000 (BEQ); pc_write = ~zero when funct3 = 001 (BNE); pc_write = 0 for any other funct3.
    - instr_done = 1. Next: FETCH.
  - JAL: A = OldPC, B = 4, ADD, result_src = 00 (target from ALUOut), pc_write = 1. Next: ALUWB, which writes the link address.
  - LUI: A = zero, B = Imm, ADD. Next: ALUWB.
- Funct decode:
  - funct3 000: SUB if op = TYPE_R and funct7b5 = 1, otherwise ADD (ADDI ignores funct7b5).
  - funct3 010: SLT. funct3 110: OR. funct3 111: AND.
  - Any other funct3: ADD, with no illegal flag.
- imm_src by op: TYPE_I_* → I, TYPE_S → S, TYPE_B → B, TYPE_J → J, TYPE_U → U, otherwise I.
- Instruction latencies (cycles, FETCH to the instr_done cycle inclusive):
  - load: 5
  - store, R-type, I-ALU, JAL, LUI: 4
  - branch: 3
  - illegal: 2, with no instr_done
- Reset mid-instruction: the FSM returns to FETCH immediately and no write enable is asserted while reset is high.

Decomposition:
- Shared package `constants`:
  - opcode localparams TYPE_*
  - ALU_* codes
  - enum state_t
  - IMM_* codes
  - RES_*, SRCA_*, SRCB_* select encodings
- Sub-module `alu_decoder`: combinational; inputs op, funct3, funct7b5, alu_op[1:0] (00 add, 01 sub, 10 funct); output alu_control. The FSM drives alu_op.

Test Plan:
- Reset: assert reset mid-MEMREAD, hold 2 cycles → state returns to FETCH; pc_write = ir_write = reg_write = mem_write = 0 throughout; first cycle after release is FETCH with ir_write = 1, pc_write = 1.
- add x3,x1,x2 (0x002081B3), then sub (0x402081B3) → FETCH, DECODE, EXECUTER, ALUWB. alu_control = 000 for add, 001 for sub in EXECUTER; reg_write = 1 and instr_done = 1 in cycle 4 only.
- lw x5,4(x0) (0x00402283) then sw x5,8(x0) (0x00502423):
  - lw → 5 cycles, adr_src = 1 in MEMREAD, result_src = 01 with reg_write in MEMWB.
  - sw → 4 cycles, mem_write = 1 only in MEMWRITE, imm_src = 001.
- beq with zero = 1 → pc_write = 1 in BRANCH; beq with zero = 0 → pc_write = 0; bne with zero = 0 → pc_write = 1. Each takes 3 cycles with alu_control = 001.
- jal x1,16 (0x010000EF) → FETCH, DECODE, JAL (pc_write = 1, imm_src = 011), ALUWB (reg_write = 1). lui (0x123452B7) → alu_src_a = 11, imm_src = 100.
- op = 7'b1111111 → illegal = 1 for one cycle in DECODE, next state FETCH, no write enables, no instr_done.
